// File: rtl/ex_stage_pipe.sv
// Registered RV64 execute stage: decoded ALU, branch resolution and next-PC,
// plus an iterative shift-add multiplier that stalls upstream while it runs.
module ex_stage_pipe #(
    parameter int XLEN   = 64,
    parameter bit MUL_EN = 1'b1,
    parameter int CNT_W  = 7
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [6:0]      i_funct7,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_alu_op,
    input  logic            i_alu_src,
    input  logic            i_branch,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_alu_result,
    output logic            o_branch_taken,
    output logic [XLEN-1:0] o_pc_next,
    output logic            o_illegal
);

    localparam int SHW = $clog2(XLEN);

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t           r_state, w_state_next;
    logic             r_out_valid, r_branch_taken, r_illegal;
    logic [XLEN-1:0]  r_alu_result, r_pc_next;
    logic [XLEN-1:0]  r_mcand, r_mplier, r_acc, r_mul_pc_next;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept, w_mul_step, w_mul_done;
    logic [XLEN-1:0]  w_opb, w_sum, w_diff, w_sll, w_srl, w_sra, w_result, w_pc_next;
    logic [SHW-1:0]   w_shamt;
    logic             w_lt, w_ltu, w_eq, w_cond, w_illegal, w_is_mul, w_taken;

    // Branch compares always use rs2; I-type always uses imm; otherwise alu_src picks.
    always_comb begin
        if (i_alu_op == 2'b01)
            w_opb = i_rs2_data;
        else if (i_alu_op == 2'b11 || i_alu_src)
            w_opb = i_imm;
        else
            w_opb = i_rs2_data;
    end

    assign w_shamt = w_opb[SHW-1:0];
    assign w_sum   = i_rs1_data + w_opb;
    assign w_diff  = i_rs1_data - w_opb;
    assign w_sll   = i_rs1_data << w_shamt;
    assign w_srl   = i_rs1_data >> w_shamt;
    assign w_sra   = $signed(i_rs1_data) >>> w_shamt;
    assign w_lt    = $signed(i_rs1_data) < $signed(w_opb);
    assign w_ltu   = i_rs1_data < w_opb;
    assign w_eq    = i_rs1_data == w_opb;

    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        w_is_mul  = 1'b0;
        w_cond    = 1'b0;
        case (i_alu_op)
            2'b00: w_result = w_sum;
            2'b01: begin
                w_result = w_diff;
                case (i_funct3)
                    3'b000:  w_cond = w_eq;
                    3'b001:  w_cond = !w_eq;
                    3'b100:  w_cond = w_lt;
                    3'b101:  w_cond = !w_lt;
                    3'b110:  w_cond = w_ltu;
                    3'b111:  w_cond = !w_ltu;
                    default: w_illegal = 1'b1;
                endcase
            end
            2'b10: begin
                case ({i_funct7, i_funct3})
                    10'b0000000_000: w_result = w_sum;
                    10'b0100000_000: w_result = w_diff;
                    10'b0000000_001: w_result = w_sll;
                    10'b0000000_010: w_result = XLEN'(w_lt);
                    10'b0000000_011: w_result = XLEN'(w_ltu);
                    10'b0000000_100: w_result = i_rs1_data ^ w_opb;
                    10'b0000000_101: w_result = w_srl;
                    10'b0100000_101: w_result = w_sra;
                    10'b0000000_110: w_result = i_rs1_data | w_opb;
                    10'b0000000_111: w_result = i_rs1_data & w_opb;
                    10'b0000001_000: begin
                        w_is_mul  = MUL_EN;
                        w_illegal = !MUL_EN;
                    end
                    default:         w_illegal = 1'b1;
                endcase
            end
            2'b11: begin
                case (i_funct3)
                    3'b000: w_result = w_sum;
                    3'b001: begin
                        if (i_funct7 == 7'b0000000) w_result = w_sll;
                        else                        w_illegal = 1'b1;
                    end
                    3'b010: w_result = XLEN'(w_lt);
                    3'b011: w_result = XLEN'(w_ltu);
                    3'b100: w_result = i_rs1_data ^ w_opb;
                    3'b101: begin
                        if (i_funct7 == 7'b0000000)      w_result = w_srl;
                        else if (i_funct7 == 7'b0100000) w_result = w_sra;
                        else                             w_illegal = 1'b1;
                    end
                    3'b110: w_result = i_rs1_data | w_opb;
                    3'b111: w_result = i_rs1_data & w_opb;
                    default: w_illegal = 1'b1;
                endcase
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_taken   = i_branch && (i_alu_op == 2'b01) && w_cond;
    assign w_pc_next = w_taken ? i_pc + (i_imm << 1) : i_pc + XLEN'(4);
    assign w_accept  = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_state <= IDLE;
        else if (i_flush) r_state <= IDLE;
        else              r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (w_accept && w_is_mul) w_state_next = MUL_BUSY;
            MUL_BUSY: if (w_mul_done)           w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Completion is held off while an earlier result still waits for downstream.
    always_comb begin
        o_in_ready = (r_state == IDLE) && (!r_out_valid || i_out_ready) && i_rst_n && !i_flush;
        w_mul_step = (r_state == MUL_BUSY) && (r_cnt != CNT_W'(XLEN));
        w_mul_done = (r_state == MUL_BUSY) && (r_cnt == CNT_W'(XLEN)) &&
                     (!r_out_valid || i_out_ready);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid    <= 1'b0;
            r_alu_result   <= '0;
            r_branch_taken <= 1'b0;
            r_pc_next      <= '0;
            r_illegal      <= 1'b0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_acc          <= '0;
            r_mul_pc_next  <= '0;
            r_cnt          <= '0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_accept && w_is_mul) begin
                r_mcand       <= i_rs1_data;
                r_mplier      <= w_opb;
                r_acc         <= '0;
                r_cnt         <= '0;
                r_mul_pc_next <= w_pc_next;
            end else if (w_mul_step) begin
                r_acc    <= r_mplier[0] ? r_acc + r_mcand : r_acc;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
            end

            if (w_accept && !w_is_mul) begin
                r_out_valid    <= 1'b1;
                r_alu_result   <= w_illegal ? '0 : w_result;
                r_branch_taken <= w_taken;
                r_pc_next      <= w_pc_next;
                r_illegal      <= w_illegal;
            end else if (w_mul_done) begin
                r_out_valid    <= 1'b1;
                r_alu_result   <= r_acc;
                r_branch_taken <= 1'b0;
                r_pc_next      <= r_mul_pc_next;
                r_illegal      <= 1'b0;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_out_valid    = r_out_valid;
    assign o_alu_result   = r_alu_result;
    assign o_branch_taken = r_branch_taken;
    assign o_pc_next      = r_pc_next;
    assign o_illegal      = r_illegal;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: ALU sweep, branches, multiplier latency,
// backpressure, flush and reset during a multiply.
module tb_ex_stage_pipe;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rstN, flush, inValid, inReady, outValid, outReady;
    logic            aluSrc, branch, branchTaken, illegal;
    logic [XLEN-1:0] pc, rs1, rs2, imm, aluResult, pcNext;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [1:0]      aluOp;
    int              checks   = 0;
    int              failures = 0;

    always #5 clk = ~clk;

    ex_stage_pipe #(.XLEN(XLEN), .MUL_EN(1'b1), .CNT_W(7)) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_flush(flush),
        .i_in_valid(inValid), .o_in_ready(inReady),
        .i_pc(pc), .i_rs1_data(rs1), .i_rs2_data(rs2), .i_imm(imm),
        .i_funct7(f7), .i_funct3(f3), .i_alu_op(aluOp), .i_alu_src(aluSrc),
        .i_branch(branch), .o_out_valid(outValid), .i_out_ready(outReady),
        .o_alu_result(aluResult), .o_branch_taken(branchTaken),
        .o_pc_next(pcNext), .o_illegal(illegal)
    );

    // Presents one op upstream with in_valid raised.
    task automatic setOp(input logic [1:0] op, input logic [6:0] fs7, input logic [2:0] fs3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] im, input logic src, input logic br,
                         input logic [XLEN-1:0] p);
        aluOp = op; f7 = fs7; f3 = fs3; rs1 = a; rs2 = b; imm = im;
        aluSrc = src; branch = br; pc = p; inValid = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rstN = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        setOp(2'b00, 7'd0, 3'd0, '0, '0, '0, 1'b0, 1'b0, '0);
        inValid = 1'b0;
        #3;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b exp=0", outValid); end
        checks++; if (aluResult !== '0) begin failures++; $display("[TB] FAIL reset_alu_result got=%h exp=0", aluResult); end
        checks++; if (branchTaken !== 1'b0) begin failures++; $display("[TB] FAIL reset_branch_taken got=%b exp=0", branchTaken); end
        checks++; if (pcNext !== '0) begin failures++; $display("[TB] FAIL reset_pc_next got=%h exp=0", pcNext); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("[TB] FAIL reset_illegal got=%b exp=0", illegal); end
        checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready got=%b exp=0", inReady); end
        tick; tick;
        rstN = 1'b1;
        #1;
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_in_ready got=%b exp=1", inReady); end
    endtask

    task automatic test_alu_sweep;
        logic [1:0]      ops [15];
        logic [6:0]      fs7 [15];
        logic [2:0]      fs3 [15];
        logic [XLEN-1:0] exp [15];
        logic            expIll [15];
        ops = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
        fs7 = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20,
                7'h00, 7'h00, 7'h20, 7'h20, 7'h01, 7'h01, 7'h00};
        fs3 = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5,
                3'd6, 3'd7, 3'd0, 3'd5, 3'd1, 3'd1, 3'd0};
        exp = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFD8,
                64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1FFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3,
                64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFE};
        expIll = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        outReady = 1'b1;
        for (int i = 0; i < 15; i++) begin
            // R-type uses rs2=3; I-type and add-path use imm=3 with a decoy rs2.
            if (ops[i] == 2'b10)
                setOp(ops[i], fs7[i], fs3[i], -64'sd5, 64'd3, 64'd77, 1'b0, 1'b0, 64'h100);
            else
                setOp(ops[i], fs7[i], fs3[i], -64'sd5, 64'd100, 64'd3, 1'b1, 1'b0, 64'h100);
            #1;
            checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL alu_in_ready[%0d] got=%b exp=1", i, inReady); end
            tick;
            checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL alu_out_valid[%0d] got=%b exp=1", i, outValid); end
            checks++; if (aluResult !== exp[i]) begin failures++; $display("[TB] FAIL alu_result[%0d] got=%h exp=%h", i, aluResult, exp[i]); end
            checks++; if (illegal !== expIll[i]) begin failures++; $display("[TB] FAIL alu_illegal[%0d] got=%b exp=%b", i, illegal, expIll[i]); end
            checks++; if (pcNext !== 64'h104) begin failures++; $display("[TB] FAIL alu_pc_next[%0d] got=%h exp=104", i, pcNext); end
        end
        inValid = 1'b0;
        tick;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL alu_drain got=%b exp=0", outValid); end
    endtask

    task automatic test_branch;
        logic [2:0]      fs3 [9];
        logic [XLEN-1:0] a [9];
        logic [XLEN-1:0] b [9];
        logic [XLEN-1:0] p [9];
        logic            br [9];
        logic            expTaken [9];
        logic            expIll [9];
        logic [XLEN-1:0] expPc [9];
        fs3 = '{3'd4, 3'd6, 3'd0, 3'd1, 3'd5, 3'd7, 3'd2, 3'd4, 3'd0};
        a   = '{-64'sd1, -64'sd1, 64'd5, 64'd5, -64'sd1, -64'sd1, 64'd5, -64'sd1, 64'd9};
        b   = '{64'd1, 64'd1, 64'd5, 64'd5, 64'd1, 64'd1, 64'd5, 64'd1, 64'd1};
        p   = '{64'h1000, 64'h1000, 64'h1000, 64'h1000, 64'h1000, 64'h1000, 64'h1000,
                64'h1000, 64'hFFFF_FFFF_FFFF_FFFC};
        br  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        expTaken = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        expIll   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        expPc    = '{64'h1020, 64'h1004, 64'h1020, 64'h1004, 64'h1004, 64'h1020,
                     64'h1004, 64'h1004, 64'h0};
        outReady = 1'b1;
        for (int i = 0; i < 9; i++) begin
            setOp(2'b01, 7'd0, fs3[i], a[i], b[i], 64'h10, 1'b0, br[i], p[i]);
            tick;
            checks++; if (branchTaken !== expTaken[i]) begin failures++; $display("[TB] FAIL br_taken[%0d] got=%b exp=%b", i, branchTaken, expTaken[i]); end
            checks++; if (pcNext !== expPc[i]) begin failures++; $display("[TB] FAIL br_pc_next[%0d] got=%h exp=%h", i, pcNext, expPc[i]); end
            checks++; if (illegal !== expIll[i]) begin failures++; $display("[TB] FAIL br_illegal[%0d] got=%b exp=%b", i, illegal, expIll[i]); end
            if (i == 0) begin
                checks++; if (aluResult !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("[TB] FAIL br_result got=%h exp=fffffffffffffffe", aluResult); end
            end
        end
        inValid = 1'b0;
        tick;
    endtask

    task automatic test_mul;
        int readyBad = 0;
        int validBad = 0;
        outReady = 1'b1;
        setOp(2'b10, 7'h01, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 1'b0, 1'b0, 64'h2000);
        tick;
        inValid = 1'b0;
        for (int k = 0; k < 65; k++) begin
            if (k < 64 && inReady !== 1'b0) readyBad++;
            if (outValid !== 1'b0) validBad++;
            tick;
        end
        checks++; if (readyBad != 0) begin failures++; $display("[TB] FAIL mul_busy_in_ready high_cycles=%0d exp=0", readyBad); end
        checks++; if (validBad != 0) begin failures++; $display("[TB] FAIL mul_early_valid early_cycles=%0d exp=0", validBad); end
        checks++; if (outValid !== 1'b1) begin failures++; $display("[TB] FAIL mul_out_valid got=%b exp=1", outValid); end
        checks++; if (aluResult !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("[TB] FAIL mul_result got=%h exp=fffffffffffffffd", aluResult); end
        checks++; if (pcNext !== 64'h2004) begin failures++; $display("[TB] FAIL mul_pc_next got=%h exp=2004", pcNext); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL mul_done_in_ready got=%b exp=1", inReady); end
        tick;
    endtask

    task automatic test_back_to_back;
        outReady = 1'b0;
        setOp(2'b10, 7'd0, 3'd0, 64'd1, 64'd1, 64'd0, 1'b0, 1'b0, 64'h0);
        tick;
        checks++; if (outValid !== 1'b1 || aluResult !== 64'd2) begin failures++; $display("[TB] FAIL bp_first valid=%b result=%h exp=1/2", outValid, aluResult); end
        setOp(2'b10, 7'd0, 3'd0, 64'd2, 64'd3, 64'd0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready[%0d] got=%b exp=0", i, inReady); end
            checks++; if (outValid !== 1'b1 || aluResult !== 64'd2) begin failures++; $display("[TB] FAIL bp_hold[%0d] valid=%b result=%h exp=1/2", i, outValid, aluResult); end
            tick;
        end
        outReady = 1'b1;
        #1;
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL bp_release_in_ready got=%b exp=1", inReady); end
        tick;
        checks++; if (outValid !== 1'b1 || aluResult !== 64'd5) begin failures++; $display("[TB] FAIL bp_second valid=%b result=%h exp=1/5", outValid, aluResult); end
        setOp(2'b10, 7'd0, 3'd0, 64'd10, 64'd1, 64'd0, 1'b0, 1'b0, 64'h0);
        tick;
        checks++; if (outValid !== 1'b1 || aluResult !== 64'd11) begin failures++; $display("[TB] FAIL bp_third valid=%b result=%h exp=1/b", outValid, aluResult); end
        setOp(2'b10, 7'd0, 3'd0, 64'd20, 64'd2, 64'd0, 1'b0, 1'b0, 64'h0);
        tick;
        checks++; if (outValid !== 1'b1 || aluResult !== 64'd22) begin failures++; $display("[TB] FAIL bp_fourth valid=%b result=%h exp=1/16", outValid, aluResult); end
        inValid = 1'b0;
        tick;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL bp_drain got=%b exp=0", outValid); end
    endtask

    task automatic test_flush;
        int staleCount = 0;
        outReady = 1'b1;
        setOp(2'b10, 7'h01, 3'd0, 64'd7, 64'd9, 64'd0, 1'b0, 1'b0, 64'h0);
        tick;
        inValid = 1'b0;
        repeat (19) tick;
        flush = 1'b1;
        setOp(2'b10, 7'd0, 3'd0, 64'd2, 64'd2, 64'd0, 1'b0, 1'b0, 64'h0);
        #1;
        checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL flush_in_ready got=%b exp=0", inReady); end
        tick;
        flush = 1'b0;
        #1;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL flush_out_valid got=%b exp=0", outValid); end
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL flush_recover_in_ready got=%b exp=1", inReady); end
        tick;
        checks++; if (outValid !== 1'b1 || aluResult !== 64'd4) begin failures++; $display("[TB] FAIL flush_add valid=%b result=%h exp=1/4", outValid, aluResult); end
        inValid = 1'b0;
        for (int k = 0; k < 70; k++) begin
            tick;
            if (outValid !== 1'b0) staleCount++;
        end
        checks++; if (staleCount != 0) begin failures++; $display("[TB] FAIL flush_stale_mul valid_cycles=%0d exp=0", staleCount); end
    endtask

    task automatic test_reset_mid_mul;
        int staleCount = 0;
        outReady = 1'b1;
        setOp(2'b10, 7'h01, 3'd0, 64'd7, 64'd9, 64'd0, 1'b0, 1'b0, 64'h0);
        tick;
        inValid = 1'b0;
        repeat (9) tick;
        #2 rstN = 1'b0;
        #1;
        checks++; if (outValid !== 1'b0) begin failures++; $display("[TB] FAIL rstmul_out_valid got=%b exp=0", outValid); end
        checks++; if (inReady !== 1'b0) begin failures++; $display("[TB] FAIL rstmul_in_ready got=%b exp=0", inReady); end
        checks++; if (aluResult !== '0) begin failures++; $display("[TB] FAIL rstmul_result got=%h exp=0", aluResult); end
        tick; tick;
        rstN = 1'b1;
        #1;
        checks++; if (inReady !== 1'b1) begin failures++; $display("[TB] FAIL rstmul_release_in_ready got=%b exp=1", inReady); end
        for (int k = 0; k < 80; k++) begin
            tick;
            if (outValid !== 1'b0) staleCount++;
        end
        checks++; if (staleCount != 0) begin failures++; $display("[TB] FAIL rstmul_stale valid_cycles=%0d exp=0", staleCount); end
    endtask

    // Scenarios run in a fixed order; each leaves the stage idle with out_ready high.
    initial begin
        test_reset;
        test_alu_sweep;
        test_branch;
        test_mul;
        test_back_to_back;
        test_flush;
        test_reset_mid_mul;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
